// File: rtl/ball_pkg.sv
// Shared types and constants for the ball motion engine: field codes,
// FSM states, per-ball storage layout and the display register index map.
package ball_pkg;

  localparam int NBALLS_DEF = 10;

  // Field codes as they appear in cfg_addr[2:0]; codes 5-7 are unused.
  typedef enum logic [2:0] {
    F_X    = 3'd0,
    F_Y    = 3'd1,
    F_VX   = 3'd2,
    F_VY   = 3'd3,
    F_SIZE = 3'd4
  } field_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEP  = 3'd1,
    WR_X  = 3'd2,
    WR_Y  = 3'd3,
    WR_SZ = 3'd4
  } state_e;

  typedef struct packed {
    logic [15:0]        x;
    logic [15:0]        y;
    logic signed [7:0]  vx;
    logic signed [7:0]  vy;
    logic [15:0]        size;
  } ball_t;

  // Display register index: three consecutive registers per ball (x, y, size).
  function automatic logic [4:0] reg_index(input logic [3:0] ball, input logic [1:0] field);
    return 5'(ball) * 5'd3 + {3'b000, field};
  endfunction

endpackage

// File: rtl/ball_motion_engine_if.sv
// Display register write port driven by the motion engine.
//
// Handshake: write-only strobe bus with no back-pressure. A word is transferred
// in every cycle where disp_write is high; disp_chipselect mirrors disp_write,
// and address/data are only meaningful in those cycles. The display accepts
// every word unconditionally, so there is no ready signal.
interface ball_motion_engine_if;
  logic        disp_chipselect;
  logic        disp_write;
  logic [4:0]  disp_address;
  logic [16:0] disp_writedata;

  modport master (
    output disp_chipselect,
    output disp_write,
    output disp_address,
    output disp_writedata
  );

  modport slave (
    input disp_chipselect,
    input disp_write,
    input disp_address,
    input disp_writedata
  );
endinterface

// File: rtl/ball_axis_step.sv
// One-axis position step: add velocity, reflect off the bounds (negating
// the velocity), then clamp the position into [MIN, MAX]. Purely combinational.
module ball_axis_step #(
  parameter int MIN = 0,
  parameter int MAX = 1279
) (
  input  logic [15:0]       pos,
  input  logic signed [7:0] v,
  output logic [15:0]       pos_n,
  output logic signed [7:0] v_n
);

  localparam logic signed [17:0] MIN_S  = 18'(MIN);
  localparam logic signed [17:0] MAX_S  = 18'(MAX);
  localparam logic signed [17:0] MIN2_S = 18'(2 * MIN);
  localparam logic signed [17:0] MAX2_S = 18'(2 * MAX);

  logic signed [17:0] n;
  logic signed [17:0] r;
  logic signed [7:0]  v_neg;

  // Step, reflect and clamp in 18-bit signed arithmetic so a 16-bit unsigned
  // position plus an 8-bit signed velocity can never wrap.
  always_comb begin
    n     = $signed({2'b00, pos}) + $signed({{10{v[7]}}, v});
    // -(-128) does not fit in 8 bits; saturate to +127 instead.
    v_neg = (v == -8'sd128) ? 8'sd127 : -v;
    r     = n;
    v_n   = v;
    if (n > MAX_S) begin
      r   = MAX2_S - n;
      v_n = v_neg;
    end else if (n < MIN_S) begin
      r   = MIN2_S - n;
      v_n = v_neg;
    end
    // A wildly out-of-range stored position can reflect past the far bound.
    if (r > MAX_S) r = MAX_S;
    if (r < MIN_S) r = MIN_S;
    pos_n = r[15:0];
  end

endmodule

// File: rtl/ball_motion_engine.sv
// Frame-synchronous ball mover. On an accepted frame tick it walks every ball:
// one STEP cycle updates position/velocity in storage, then three cycles stream
// x, y and size to the display register port. Software configures balls at
// any time through the cfg port; a cfg write beats the step write-back for the
// field it targets.
module ball_motion_engine
  import ball_pkg::*;
#(
  parameter int NBALLS = NBALLS_DEF,
  parameter int XMIN   = 0,
  parameter int XMAX   = 1279,
  parameter int YMIN   = 0,
  parameter int YMAX   = 479
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run,
  input  logic                        frame_tick,
  input  logic                        cfg_write,
  input  logic [6:0]                  cfg_addr,
  input  logic [15:0]                 cfg_writedata,
  input  logic                        overrun_clr,
  ball_motion_engine_if.master        disp,
  output logic                        busy,
  output logic                        overrun,
  output state_e                      dbg_state,
  output logic [3:0]                  dbg_ball
);

  ball_t       balls_q [NBALLS];
  state_e      state_q, state_n;
  logic [3:0]  idx_q, idx_n;

  ball_t       cur;
  logic [15:0] x_n, y_n;
  logic signed [7:0] vx_n, vy_n;

  logic [3:0]  cfg_ball;
  logic [2:0]  cfg_field;
  logic        cfg_hit;
  logic        cfg_this;

  logic        wr_n;
  logic [4:0]  addr_n;
  logic [15:0] data_n;

  assign cfg_ball  = cfg_addr[6:3];
  assign cfg_field = cfg_addr[2:0];
  assign cfg_hit   = cfg_write && (int'(cfg_ball) < NBALLS) && (cfg_field <= 3'd4);
  assign cfg_this  = cfg_hit && (cfg_ball == idx_q);

  assign cur       = balls_q[idx_q];
  assign dbg_state = state_q;
  assign dbg_ball  = idx_q;

  ball_axis_step #(.MIN(XMIN), .MAX(XMAX)) u_step_x (
    .pos   (cur.x),
    .v     (cur.vx),
    .pos_n (x_n),
    .v_n   (vx_n)
  );

  ball_axis_step #(.MIN(YMIN), .MAX(YMAX)) u_step_y (
    .pos   (cur.y),
    .v     (cur.vy),
    .pos_n (y_n),
    .v_n   (vy_n)
  );

  // Ball storage: step write-back first, cfg write second so cfg wins per field.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NBALLS; b++) balls_q[b] <= '0;
    end else begin
      for (int b = 0; b < NBALLS; b++) begin
        if (state_q == STEP && idx_q == 4'(b)) begin
          balls_q[b].x  <= x_n;
          balls_q[b].y  <= y_n;
          balls_q[b].vx <= vx_n;
          balls_q[b].vy <= vy_n;
        end
        if (cfg_hit && cfg_ball == 4'(b)) begin
          case (cfg_field)
            3'd0:    balls_q[b].x    <= cfg_writedata;
            3'd1:    balls_q[b].y    <= cfg_writedata;
            3'd2:    balls_q[b].vx   <= cfg_writedata[7:0];
            3'd3:    balls_q[b].vy   <= cfg_writedata[7:0];
            3'd4:    balls_q[b].size <= cfg_writedata;
            default: ;
          endcase
        end
      end
    end
  end

  // FSM state and ball index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
    end
  end

  // Next-state logic: one STEP plus three writes per ball, then back to IDLE.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    case (state_q)
      IDLE: begin
        if (frame_tick && run) begin
          state_n = STEP;
          idx_n   = '0;
        end
      end
      STEP:  state_n = WR_X;
      WR_X:  state_n = WR_Y;
      WR_Y:  state_n = WR_SZ;
      WR_SZ: begin
        if (idx_q == 4'(NBALLS - 1)) begin
          state_n = IDLE;
        end else begin
          state_n = STEP;
          idx_n   = idx_q + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Display word for the upcoming write state. The same cycle's cfg write is
  // folded in so the display always shows what storage will hold.
  always_comb begin
    wr_n   = 1'b0;
    addr_n = '0;
    data_n = '0;
    case (state_n)
      WR_X: begin
        wr_n   = 1'b1;
        addr_n = reg_index(idx_q, 2'd0);
        data_n = (cfg_this && cfg_field == 3'd0) ? cfg_writedata : x_n;
      end
      WR_Y: begin
        wr_n   = 1'b1;
        addr_n = reg_index(idx_q, 2'd1);
        data_n = (cfg_this && cfg_field == 3'd1) ? cfg_writedata : cur.y;
      end
      WR_SZ: begin
        wr_n   = 1'b1;
        addr_n = reg_index(idx_q, 2'd2);
        data_n = (cfg_this && cfg_field == 3'd4) ? cfg_writedata : cur.size;
      end
      default: ;
    endcase
  end

  // Registered display port and busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp.disp_write      <= 1'b0;
      disp.disp_chipselect <= 1'b0;
      disp.disp_address    <= '0;
      disp.disp_writedata  <= '0;
      busy                 <= 1'b0;
    end else begin
      disp.disp_write      <= wr_n;
      disp.disp_chipselect <= wr_n;
      disp.disp_address    <= addr_n;
      disp.disp_writedata  <= {1'b0, data_n};
      busy                 <= (state_n != IDLE);
    end
  end

  // Sticky overrun: an enabled tick arriving mid-update; set beats clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (frame_tick && run && state_q != IDLE) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ball_motion_engine.sv
// Directed bench for ball_motion_engine. Stimulus pushes the expected display
// words (with their expected cycle) into a queue; a monitor pops and compares
// each write as it appears on the display port.
module tb_ball_motion_engine;
  import ball_pkg::*;

  localparam int NB = 10;
  localparam int W  = 38;   // {cycle[15:0], addr[4:0], data[16:0]}

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        frame_tick = 1'b0;
  logic        cfg_write = 1'b0;
  logic [6:0]  cfg_addr = '0;
  logic [15:0] cfg_writedata = '0;
  logic        overrun_clr = 1'b0;
  logic        busy, overrun;
  state_e      dbg_state;
  logic [3:0]  dbg_ball;

  ball_motion_engine_if disp_bus ();

  ball_motion_engine dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .frame_tick    (frame_tick),
    .cfg_write     (cfg_write),
    .cfg_addr      (cfg_addr),
    .cfg_writedata (cfg_writedata),
    .overrun_clr   (overrun_clr),
    .disp          (disp_bus.master),
    .busy          (busy),
    .overrun       (overrun),
    .dbg_state     (dbg_state),
    .dbg_ball      (dbg_ball)
  );

  // ---------------- clock / cycle counter ----------------
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  int ex [NB];
  int ey [NB];
  int es [NB];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every display write must match the head of the expected queue.
  always @(negedge clk) begin
    if (disp_bus.disp_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'b0, disp_bus.disp_address}, 32'hFFFF_FFFF);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(disp_bus.disp_address), 32'(e[21:17]));
        check("wr_data", 32'(disp_bus.disp_writedata), 32'(e[16:0]));
        check("wr_cycle", 32'(cyc[15:0]), 32'(e[37:22]));
        check("wr_cs", 32'(disp_bus.disp_chipselect), 32'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_exp();
    for (int b = 0; b < NB; b++) begin
      ex[b] = 0; ey[b] = 0; es[b] = 0;
    end
  endtask

  task automatic set_exp(input int b, input int x, input int y, input int s);
    ex[b] = x; ey[b] = y; es[b] = s;
  endtask

  task automatic cfg(input int b, input int f, input logic [15:0] d);
    @(posedge clk); #1;
    cfg_write     = 1'b1;
    cfg_addr      = {4'(b), 3'(f)};
    cfg_writedata = d;
    @(posedge clk); #1;
    cfg_write     = 1'b0;
  endtask

  // One frame. inj_kind: 0 none, 1 extra tick, 2 cfg ball3 x=500, 3 reset.
  // Injection is driven during cycle T+inj_k (T = the tick cycle).
  task automatic run_frame(input int inj_k, input int inj_kind);
    int  c0;
    bit  aborted;
    aborted = 1'b0;
    @(posedge clk); #1;
    c0 = cyc;
    for (int b = 0; b < NB; b++) begin
      exp_q.push_back({16'(c0 + 2 + 4*b), 5'(3*b),     17'(ex[b])});
      exp_q.push_back({16'(c0 + 3 + 4*b), 5'(3*b + 1), 17'(ey[b])});
      exp_q.push_back({16'(c0 + 4 + 4*b), 5'(3*b + 2), 17'(es[b])});
    end
    frame_tick = 1'b1;
    for (int k = 1; k <= 42 && !aborted; k++) begin
      @(posedge clk); #1;
      frame_tick = 1'b0;
      cfg_write  = 1'b0;
      if (k == 1) begin
        check("busy_T+1", 32'(busy), 32'd1);
        check("state_T+1", 32'(dbg_state), 32'(STEP));
      end
      if (k == 40) check("busy_T+40", 32'(busy), 32'd1);
      if (k == 41) begin
        check("busy_T+41", 32'(busy), 32'd0);
        check("state_T+41", 32'(dbg_state), 32'(IDLE));
      end
      if (k == inj_k) begin
        case (inj_kind)
          1: frame_tick = 1'b1;
          2: begin
            cfg_write     = 1'b1;
            cfg_addr      = {4'd3, 3'd0};
            cfg_writedata = 16'd500;
          end
          3: begin
            reset = 1'b1;
            #1;
            check("rst_disp_write", 32'(disp_bus.disp_write), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_state", 32'(dbg_state), 32'(IDLE));
            exp_q.delete();
            aborted = 1'b1;
          end
          default: ;
        endcase
      end
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_write"}, 32'(disp_bus.disp_write), 32'd0);
    check({tag, "_cs"}, 32'(disp_bus.disp_chipselect), 32'd0);
    check({tag, "_addr"}, 32'(disp_bus.disp_address), 32'd0);
    check({tag, "_data"}, 32'(disp_bus.disp_writedata), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    run   = 1'b1;

    // All-zero frame.
    clear_exp();
    run_frame(0, 0);

    // Configure balls: plain motion, right/top bounce, left wall with -128.
    cfg(0, 0, 16'd100); cfg(0, 1, 16'd50); cfg(0, 2, 16'h0003); cfg(0, 3, 16'h00FE); cfg(0, 4, 16'd100);
    cfg(1, 0, 16'd1278); cfg(1, 1, 16'd1); cfg(1, 2, 16'h0005); cfg(1, 3, 16'h00FC); cfg(1, 4, 16'd7);
    cfg(2, 0, 16'd1); cfg(2, 1, 16'd479); cfg(2, 2, 16'h0080); cfg(2, 3, 16'h007F);
    cfg(9, 0, 16'd1279); cfg(9, 4, 16'hABCD);
    // Ignored writes: out-of-range ball and unused field codes.
    cfg(10, 0, 16'd999); cfg(0, 5, 16'h1234); cfg(0, 7, 16'h5678);

    // Frame A
    clear_exp();
    set_exp(0, 103, 48, 100);
    set_exp(1, 1275, 3, 7);
    set_exp(2, 127, 352, 0);
    set_exp(9, 1279, 0, 16'hABCD);
    run_frame(0, 0);

    // Frame B: bounced velocities carry on.
    clear_exp();
    set_exp(0, 106, 46, 100);
    set_exp(1, 1270, 7, 7);
    set_exp(2, 254, 225, 0);
    set_exp(9, 1279, 0, 16'hABCD);
    run_frame(0, 0);

    // Frame C: extra tick at T+10 is ignored but flags overrun.
    check("overrun_before", 32'(overrun), 32'd0);
    clear_exp();
    set_exp(0, 109, 44, 100);
    set_exp(1, 1265, 11, 7);
    set_exp(2, 381, 98, 0);
    set_exp(9, 1279, 0, 16'hABCD);
    run_frame(10, 1);
    check("overrun_set", 32'(overrun), 32'd1);
    @(posedge clk); #1;
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;
    check("overrun_clr", 32'(overrun), 32'd0);

    // Frame D: cfg write to ball3 x during ball3 STEP wins.
    clear_exp();
    set_exp(0, 112, 42, 100);
    set_exp(1, 1260, 15, 7);
    set_exp(2, 508, 29, 0);
    set_exp(3, 500, 0, 0);
    set_exp(9, 1279, 0, 16'hABCD);
    run_frame(13, 2);

    // Frame E: reset at T+7 abandons the frame.
    clear_exp();
    set_exp(0, 115, 40, 100);
    set_exp(1, 1255, 19, 7);
    run_frame(7, 3);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("post_reset");

    // Tick with run=0: nothing happens.
    run = 1'b0;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("run0_busy", 32'(busy), 32'd0);
    check("run0_overrun", 32'(overrun), 32'd0);
    check("run0_state", 32'(dbg_state), 32'(IDLE));

    // Frame F: restart from ball0 with zeroed storage.
    run = 1'b1;
    clear_exp();
    run_frame(0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ball_motion_engine.md
# ball_motion_engine

Frame-synchronous motion stepper for the 10-ball VGA display. Holds per-ball position, velocity and size. On each frame tick (start of vertical blank) it advances every ball by its velocity, reflects off the screen bounds, and streams the 30 resulting x/y/size words into the display's register write port. It sits directly upstream of the display peripheral. Software configures the balls; the hardware moves them without per-frame CPU writes.

## Interface
Parameters:
- NBALLS, 10, number of balls; display register index = 3*ball + field.
- XMIN, 0, left bound in display x units (hcount units, 0..1279).
- XMAX, 1279, right bound.
- YMIN, 0, top bound in lines.
- YMAX, 479, bottom bound.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high.
- run  in  1  enables frame updates; sampled only with frame_tick.
- frame_tick  in  1  one-cycle pulse at first line of vertical blank.
- cfg_write  in  1  configuration write strobe.
- cfg_addr  in  7  [6:3] ball, [2:0] field: 0 x, 1 y, 2 vx, 3 vy, 4 size; 5-7 ignored.
- cfg_writedata  in  16  configuration data; vx/vy use bits [7:0] as signed.
- overrun_clr  in  1  clears overrun.
- disp_chipselect  out  1  equals disp_write.
- disp_write  out  1  display register write strobe.
- disp_address  out  5  display register index.
- disp_writedata  out  17  display data, bit 16 always 0.
- busy  out  1  high while a frame update is in progress.
- overrun  out  1  sticky; a tick arrived while busy.

## Operation
- Storage per ball: x[15:0], y[15:0], vx[7:0] signed, vy[7:0] signed, size[15:0]. All fields reset to 0.
- cfg writes take effect in storage the next cycle, regardless of state.
  - A write to ball >= NBALLS or to field 5-7 is ignored.
  - If a cfg write and the update write-back target the same ball in the same cycle, the cfg value wins for the written field. The other fields of that ball take the update result.
- FSM states: IDLE, STEP, WR_X, WR_Y, WR_SZ; ball index i in 0..NBALLS-1.
  - IDLE -> STEP (i=0) when frame_tick && run.
  - STEP -> WR_X -> WR_Y -> WR_SZ.
  - WR_SZ -> STEP (i+1), or -> IDLE if i == NBALLS-1.
- STEP, per axis, uses 18-bit signed arithmetic:
  - n = pos + sign-extended v.
  - If n > MAX: pos = 2*MAX - n, v = -v.
  - Else if n < MIN: pos = 2*MIN - n, v = -v.
  - Else pos = n.
  - The result is clamped to [MIN, MAX].
  - Negating -128 gives +127.
- Write states present the updated values:
  - WR_X: address 3i, data x.
  - WR_Y: address 3i+1, data y.
  - WR_SZ: address 3i+2, data size.
- frame_tick outside IDLE is ignored and sets overrun.
- overrun_clr clears overrun; a simultaneous set wins.
- frame_tick with run=0 is ignored and does not set overrun.

## Timing
- All outputs are registered. Reset values: disp_* = 0, busy = 0, overrun = 0, state IDLE.
- Tick sampled at edge T:
  - busy high from T+1.
  - Ball i: STEP at T+1+4i; x, y, size writes at T+2+4i, T+3+4i, T+4+4i.
  - Last write (address 29) at T+40; busy low and IDLE at T+41.
- A frame update is 40 cycles, well inside vertical blank.
- disp_write is high for exactly one cycle per word; no back-pressure from the display.
- Reset mid-update: outputs go to 0 immediately, storage is zeroed, and the partial frame is abandoned.

## Structure
- Package ball_pkg:
  - NBALLS default.
  - field_e (X, Y, VX, VY, SIZE).
  - state_e.
  - ball_t struct {x, y, vx, vy, size}.
- Sub-module ball_axis_step: combinational step/reflect/clamp for one axis.
  - Parameters MIN, MAX.
  - Ports pos, v -> pos_n, v_n.
  - Instantiated twice, for x and y.

## Test plan
- Reset: all outputs 0. With run=1 and no cfg, a tick writes 30 zero words at addresses 0..29, cycles T+2..T+40.
- Ball0 set to x=100, y=50, vx=+3, vy=-2, size=100; tick -> addr0=103, addr1=48, addr2=100; busy low at T+41.
- Right bounce: x=1278, vx=+5 -> x=1275, vx=-5; next frame x=1270. Top bounce: y=1, vy=-4 -> y=3, vy=+4.
- Second tick at T+10 -> ignored, overrun=1, write sequence unchanged; overrun_clr -> overrun=0.
- cfg write of ball3 x=500 during ball3 STEP -> addr9 shows 500. vx=-128 at the left wall -> vx becomes +127.
- Reset at T+7 -> disp_write low at once. After release, a tick restarts at ball0 with zeroed state.
